seq_arith_unit: RTL and testbench
=================================

// Module: seq_arith_unit
// PURPOSE
//  Parametrised, multi-cycle successor to the processor's combinational arithmetic unit.
//  Adds WIDTH generalisation, registered results, carry/overflow flags, iterative
//  multiply and optional iterative unsigned divide/remainder.
//  Sits between the decode stage and writeback.
//  Uses a valid/ready handshake so the controller can stall on multi-cycle ops.
// PARAMETERS
//  WIDTH   32   operand/result width in bits (>=4)
//  CNT_W   $clog2(WIDTH+1)   iteration counter width (derived, not overridden)
// PORTS
//  clk        in   1      single clock, all state on rising edge
//  rst        in   1      asynchronous, active-high reset
//  in_valid   in   1      operands and op presented
//  in_ready   out  1      unit can accept an op this cycle
//  op         in   3      000 ADD, 001 SUB, 010 SLT (signed), 011 SLTU, 100 MUL (low half),
//                         101 DIVU, 110 REMU, 111 reserved
//  in1        in   WIDTH  operand A
//  in2        in   WIDTH  operand B
//  cin        in   1      carry-in for ADD only (ignored otherwise)
//  out_valid  out  1      result/flags valid, held until out_ready
//  out_ready  in   1      consumer takes result
//  out        out  WIDTH  result
//  zero       out  1      out == 0
//  sign       out  1      out[WIDTH-1]
//  carry      out  1      ADD: carry out; SUB: NOT borrow; else 0
//  ovf        out  1      signed overflow for ADD/SUB; else 0
//  err        out  1      reserved op (or disabled op) accepted
// BEHAVIOUR
//  - Reset: state IDLE; in_ready=1 after reset release; out_valid=0.
//    All other outputs 0, iteration registers cleared.
//  - Accept: the op is captured when in_valid && in_ready.
//  - in_ready = (state==IDLE) || (state==DONE && out_ready).
//    This allows back-to-back ops.
//  - FSM:
//      IDLE -> DONE on accept of a 1-cycle op.
//      IDLE -> BUSY on accept of MUL, DIVU or REMU.
//      BUSY -> DONE when the iteration count reaches WIDTH.
//      DONE -> IDLE on out_ready without a new accept.
//      DONE -> DONE or BUSY on out_ready with a new accept.
//  - Latency (accept edge to out_valid):
//      1-cycle ops (ADD, SUB, SLT, SLTU, reserved): 1 cycle.
//      MUL, DIVU, REMU: WIDTH+1 cycles.
//  - out and the flags are stable for as long as out_valid=1 && !out_ready.
//  - in_valid during BUSY is ignored (in_ready=0), and no inputs are sampled.
//  - SUB: in1 + ~in2 + 1.
//  - SLT: out = {0.., (diff sign) XOR ovf}.
//  - SLTU: out = {0.., borrow}.
//  - MUL: shift-add, 1 bit per cycle; result is the low WIDTH bits of the unsigned product
//    (also equal to the signed low half).
//  - DIVU/REMU: restoring division, 1 quotient bit per cycle.
//  - Divide by zero: quotient = all ones, remainder = in1, err=0.
//    Same WIDTH+1 latency.
//  - Reserved op 111: out=0, zero=1, err=1, 1-cycle latency.
//  - rst asserted mid-BUSY: the operation is aborted and all outputs return to reset values.
//    No result is produced.
// CONFIGURATION
//  ARITH_DIV_EN defined:
//    DIVU/REMU are implemented as described above.
//  ARITH_DIV_EN undefined:
//    No divider datapath is built.
//    Ops 101/110 behave as reserved: out=0, zero=1, err=1, 1-cycle latency.
// STRUCTURE
//  - Package arith_pkg:
//      op localparams OP_ADD..OP_RSV;
//      FSM state encoding S_IDLE/S_BUSY/S_DONE;
//      helper is_multicycle(op).
//  - Sub-module arith_iter_core:
//      shift-add multiplier and restoring divider sharing one WIDTH+1 adder;
//      iteration counter;
//      start/done pulses.
//  - Top holds the FSM, the 1-cycle adder path, the flag logic and the output registers.
// TESTING
//  1. WIDTH=32, ADD 0xFFFFFFFF+0x00000001 cin=0 -> out=0, zero=1, carry=1, ovf=0,
//     out_valid 1 cycle after accept.
//  2. SUB 0x80000000-0x00000001 -> out=0x7FFFFFFF, ovf=1, carry=1.
//     SLT with the same operands -> out=1.
//     SLTU with the same operands -> out=0.
//  3. MUL 0x00012345*0x00000100 -> out=0x01234500, out_valid exactly 33 cycles after accept.
//     in_ready=0 throughout BUSY.
//  4. DIVU 100/7 -> 14; REMU 100/7 -> 2.
//     DIVU x/0 -> 0xFFFFFFFF; REMU x/0 -> x.
//     Build without ARITH_DIV_EN -> err=1, out=0, 1-cycle latency.
//  5. Hold out_ready=0 for 5 cycles after a result -> out/flags stable.
//     Then out_ready=1 with in_valid=1 -> the new op is accepted in the same cycle.
//  6. Assert rst during cycle 10 of a MUL -> out_valid=0, in_ready=1 after release.
//     The next ADD 2+3 -> 5.

Source files
------------

// File: rtl/arith_pkg.sv
// ---------------------------------------------------------------------------
// arith_pkg
// Shared definitions for the sequential arithmetic unit:
//   - op encodings OP_ADD .. OP_RSV
//   - FSM state encodings S_IDLE / S_BUSY / S_DONE
//   - is_multicycle(): ops that go through the iterative core
// Build option: ARITH_DIV_EN enables DIVU/REMU. Without it those ops are
// handled like the reserved op.
// ---------------------------------------------------------------------------
package arith_pkg;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_SLT  = 3'b010;
    localparam logic [2:0] OP_SLTU = 3'b011;
    localparam logic [2:0] OP_MUL  = 3'b100;
    localparam logic [2:0] OP_DIVU = 3'b101;
    localparam logic [2:0] OP_REMU = 3'b110;
    localparam logic [2:0] OP_RSV  = 3'b111;

    localparam logic [1:0] S_IDLE = 2'b00;
    localparam logic [1:0] S_BUSY = 2'b01;
    localparam logic [1:0] S_DONE = 2'b10;

    // True for ops that need WIDTH iterations of the shared core.
    function automatic logic is_multicycle(input logic [2:0] op);
        logic res;
        case (op)
            OP_MUL:  res = 1'b1;
`ifdef ARITH_DIV_EN
            OP_DIVU: res = 1'b1;
            OP_REMU: res = 1'b1;
`endif
            default: res = 1'b0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/arith_iter_core.sv
// ---------------------------------------------------------------------------
// arith_iter_core
// Iterative engine: shift-add multiplier (low half of the product) and, with
// ARITH_DIV_EN defined, a restoring divider. One bit per cycle, WIDTH cycles.
// Multiply and divide share the same three registers:
//   acc_r    : product accumulator   / partial remainder
//   mcand_r  : multiplicand (<<1)    / divisor
//   mplier_r : multiplier (>>1)      / dividend shifting out, quotient in
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   start           load operands and begin (one-cycle pulse)
//   div_mode        0 = multiply, 1 = divide (only honoured with ARITH_DIV_EN)
//   in1, in2        operands (in1 = dividend / multiplicand)
//   done            high in the cycle the final iteration is taken
//   acc_res         product or remainder after the final iteration
//   q_res           quotient after the final iteration
// acc_res/q_res are the next-state values so the caller can capture the
// result on the same edge that retires the last iteration.
// ---------------------------------------------------------------------------
module arith_iter_core #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             div_mode,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    output logic             done,
    output logic [WIDTH-1:0] acc_res,
    output logic [WIDTH-1:0] q_res
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] ONE_CNT  = CNT_W'(1);

    logic             busy_r;
    logic [CNT_W-1:0] cnt_r;
    logic [WIDTH-1:0] acc_r;
    logic [WIDTH-1:0] mcand_r;
    logic [WIDTH-1:0] mplier_r;
    logic [WIDTH-1:0] acc_nxt_s;
    logic [WIDTH-1:0] mcand_nxt_s;
    logic [WIDTH-1:0] mplier_nxt_s;
    logic             start_s;
    logic             done_s;

`ifdef ARITH_DIV_EN
    logic             div_r;
    logic [WIDTH:0]   part_s;
    logic [WIDTH:0]   add_a_s;
    logic [WIDTH:0]   add_b_s;
    logic             add_c_s;
    logic [WIDTH+1:0] sum_s;
    logic             fit_s;

    assign start_s = start;

    // One step of either algorithm through the shared WIDTH+1 adder.
    // Divide subtracts the divisor from {rem, next dividend bit}; the top
    // sum bit is set exactly when the trial subtraction does not borrow.
    // A zero divisor always "fits", yielding all-ones quotient and rem=in1.
    always_comb begin
        part_s       = {acc_r, mplier_r[WIDTH-1]};
        add_a_s      = {(WIDTH+1){1'b0}};
        add_b_s      = {(WIDTH+1){1'b0}};
        add_c_s      = 1'b0;
        acc_nxt_s    = acc_r;
        mcand_nxt_s  = mcand_r;
        mplier_nxt_s = mplier_r;
        if (div_r) begin
            add_a_s = part_s;
            add_b_s = ~{1'b0, mcand_r};
            add_c_s = 1'b1;
        end else begin
            add_a_s = {1'b0, acc_r};
            add_b_s = {1'b0, (mplier_r[0] ? mcand_r : {WIDTH{1'b0}})};
            add_c_s = 1'b0;
        end
        sum_s = {1'b0, add_a_s} + {1'b0, add_b_s} + {{(WIDTH+1){1'b0}}, add_c_s};
        fit_s = sum_s[WIDTH+1];
        if (div_r) begin
            acc_nxt_s    = fit_s ? sum_s[WIDTH-1:0] : part_s[WIDTH-1:0];
            mcand_nxt_s  = mcand_r;
            mplier_nxt_s = {mplier_r[WIDTH-2:0], fit_s};
        end else begin
            acc_nxt_s    = sum_s[WIDTH-1:0];
            mcand_nxt_s  = {mcand_r[WIDTH-2:0], 1'b0};
            mplier_nxt_s = {1'b0, mplier_r[WIDTH-1:1]};
        end
    end

    // Remember which algorithm was started.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_r <= 1'b0;
        end else if (start_s) begin
            div_r <= div_mode;
        end else begin
            div_r <= div_r;
        end
    end
`else
    // Without the divider only multiply requests may start the engine.
    assign start_s = start & ~div_mode;

    // One shift-add multiply step.
    always_comb begin
        acc_nxt_s    = acc_r + (mplier_r[0] ? mcand_r : {WIDTH{1'b0}});
        mcand_nxt_s  = {mcand_r[WIDTH-2:0], 1'b0};
        mplier_nxt_s = {1'b0, mplier_r[WIDTH-1:1]};
    end
`endif

    assign done_s  = busy_r && (cnt_r == LAST_CNT);
    assign done    = done_s;
    assign acc_res = acc_nxt_s;
    assign q_res   = mplier_nxt_s;

    // Operand load on start, then one iteration per cycle while busy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_r   <= 1'b0;
            cnt_r    <= {CNT_W{1'b0}};
            acc_r    <= {WIDTH{1'b0}};
            mcand_r  <= {WIDTH{1'b0}};
            mplier_r <= {WIDTH{1'b0}};
        end else if (start_s) begin
            busy_r   <= 1'b1;
            cnt_r    <= {CNT_W{1'b0}};
            acc_r    <= {WIDTH{1'b0}};
`ifdef ARITH_DIV_EN
            mcand_r  <= div_mode ? in2 : in1;
            mplier_r <= div_mode ? in1 : in2;
`else
            mcand_r  <= in1;
            mplier_r <= in2;
`endif
        end else if (busy_r) begin
            busy_r   <= ~done_s;
            cnt_r    <= cnt_r + ONE_CNT;
            acc_r    <= acc_nxt_s;
            mcand_r  <= mcand_nxt_s;
            mplier_r <= mplier_nxt_s;
        end else begin
            busy_r   <= busy_r;
            cnt_r    <= cnt_r;
            acc_r    <= acc_r;
            mcand_r  <= mcand_r;
            mplier_r <= mplier_r;
        end
    end

endmodule

// File: rtl/seq_arith_unit.sv
// ---------------------------------------------------------------------------
// seq_arith_unit
// Multi-cycle arithmetic unit between decode and writeback with valid/ready
// handshakes on both sides. ADD/SUB/SLT/SLTU (and reserved/disabled ops)
// complete in one cycle; MUL, DIVU, REMU take WIDTH+1 cycles via
// arith_iter_core. Results and flags are registered and held until taken.
// Build option: ARITH_DIV_EN enables DIVU/REMU; otherwise they act as
// reserved (out=0, zero=1, err=1, one cycle).
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   in_valid / in_ready   operand handshake (op, in1, in2, cin)
//   op                    operation select (see arith_pkg)
//   in1, in2, cin         operands; cin only used by ADD
//   out_valid / out_ready result handshake
//   out                   result
//   zero, sign            out==0, out MSB
//   carry, ovf            ADD/SUB carry (SUB: not-borrow) and signed overflow
//   err                   reserved or disabled op was accepted
// ---------------------------------------------------------------------------
module seq_arith_unit
    import arith_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             zero,
    output logic             sign,
    output logic             carry,
    output logic             ovf,
    output logic             err
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    logic [1:0]       state_r;
    logic [1:0]       state_nxt_s;
    logic [2:0]       op_r;
    logic             accept_s;
    logic             mc_s;
    logic             core_start_s;
    logic             core_done_s;
    logic [WIDTH-1:0] core_acc_s;
    logic [WIDTH-1:0] core_q_s;

    logic [WIDTH-1:0] b_op_s;
    logic             c_op_s;
    logic [WIDTH:0]   sum_s;
    logic             add_ovf_s;
    logic [WIDTH-1:0] fast_out_s;
    logic             fast_carry_s;
    logic             fast_ovf_s;
    logic             fast_err_s;
    logic [WIDTH-1:0] mc_out_s;

    logic [WIDTH-1:0] out_r;
    logic             zero_r;
    logic             sign_r;
    logic             carry_r;
    logic             ovf_r;
    logic             err_r;

    assign in_ready     = (state_r == S_IDLE) || ((state_r == S_DONE) && out_ready);
    assign accept_s     = in_valid && in_ready;
    assign mc_s         = is_multicycle(op);
    assign core_start_s = accept_s && mc_s;
    assign out_valid    = (state_r == S_DONE);

    assign out   = out_r;
    assign zero  = zero_r;
    assign sign  = sign_r;
    assign carry = carry_r;
    assign ovf   = ovf_r;
    assign err   = err_r;

    arith_iter_core #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_core (
        .clk      (clk),
        .rst      (rst),
        .start    (core_start_s),
        .div_mode (op != OP_MUL),
        .in1      (in1),
        .in2      (in2),
        .done     (core_done_s),
        .acc_res  (core_acc_s),
        .q_res    (core_q_s)
    );

    // Single-cycle path: one adder serves ADD (in2, cin) and the
    // subtract-based ops (~in2, carry-in 1). SLT corrects the difference
    // sign with overflow; SLTU is the borrow (inverted carry).
    always_comb begin
        b_op_s       = (op == OP_ADD) ? in2 : ~in2;
        c_op_s       = (op == OP_ADD) ? cin : 1'b1;
        sum_s        = {1'b0, in1} + {1'b0, b_op_s} + {{WIDTH{1'b0}}, c_op_s};
        add_ovf_s    = (in1[WIDTH-1] == b_op_s[WIDTH-1]) && (sum_s[WIDTH-1] != in1[WIDTH-1]);
        fast_out_s   = {WIDTH{1'b0}};
        fast_carry_s = 1'b0;
        fast_ovf_s   = 1'b0;
        fast_err_s   = 1'b0;
        case (op)
            OP_ADD, OP_SUB: begin
                fast_out_s   = sum_s[WIDTH-1:0];
                fast_carry_s = sum_s[WIDTH];
                fast_ovf_s   = add_ovf_s;
            end
            OP_SLT:  fast_out_s = {{(WIDTH-1){1'b0}}, sum_s[WIDTH-1] ^ add_ovf_s};
            OP_SLTU: fast_out_s = {{(WIDTH-1){1'b0}}, ~sum_s[WIDTH]};
            OP_RSV:  fast_err_s = 1'b1;
            // Multi-cycle ops only land here when their datapath is not built.
            default: fast_err_s = 1'b1;
        endcase
    end

    // Pick the iterative result for the op that started the engine.
    always_comb begin
        case (op_r)
            OP_DIVU: mc_out_s = core_q_s;
            OP_REMU: mc_out_s = core_acc_s;
            default: mc_out_s = core_acc_s;
        endcase
    end

    // Handshake FSM next state.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (accept_s) begin
                    state_nxt_s = mc_s ? S_BUSY : S_DONE;
                end else begin
                    state_nxt_s = S_IDLE;
                end
            end
            S_BUSY: begin
                if (core_done_s) begin
                    state_nxt_s = S_DONE;
                end else begin
                    state_nxt_s = S_BUSY;
                end
            end
            S_DONE: begin
                if (accept_s) begin
                    state_nxt_s = mc_s ? S_BUSY : S_DONE;
                end else if (out_ready) begin
                    state_nxt_s = S_IDLE;
                end else begin
                    state_nxt_s = S_DONE;
                end
            end
            default: state_nxt_s = S_IDLE;
        endcase
    end

    // State, captured op and result/flag registers. Results only change on
    // a single-cycle accept or on the last iteration, so they stay stable
    // while a result waits for out_ready.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= S_IDLE;
            op_r    <= OP_ADD;
            out_r   <= {WIDTH{1'b0}};
            zero_r  <= 1'b0;
            sign_r  <= 1'b0;
            carry_r <= 1'b0;
            ovf_r   <= 1'b0;
            err_r   <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            if (accept_s) begin
                op_r <= op;
            end else begin
                op_r <= op_r;
            end
            if (accept_s && !mc_s) begin
                out_r   <= fast_out_s;
                zero_r  <= (fast_out_s == {WIDTH{1'b0}});
                sign_r  <= fast_out_s[WIDTH-1];
                carry_r <= fast_carry_s;
                ovf_r   <= fast_ovf_s;
                err_r   <= fast_err_s;
            end else if (core_done_s) begin
                out_r   <= mc_out_s;
                zero_r  <= (mc_out_s == {WIDTH{1'b0}});
                sign_r  <= mc_out_s[WIDTH-1];
                carry_r <= 1'b0;
                ovf_r   <= 1'b0;
                err_r   <= 1'b0;
            end else begin
                out_r   <= out_r;
                zero_r  <= zero_r;
                sign_r  <= sign_r;
                carry_r <= carry_r;
                ovf_r   <= ovf_r;
                err_r   <= err_r;
            end
        end
    end

endmodule

// File: tb/tb_seq_arith_unit.sv
// ---------------------------------------------------------------------------
// tb_seq_arith_unit
// Directed bench for seq_arith_unit (WIDTH=32). Expected values are
// hand-computed constants. Honours ARITH_DIV_EN in the same way as the RTL.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_seq_arith_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  op = 3'b000;
    logic [31:0] in1 = 32'h0;
    logic [31:0] in2 = 32'h0;
    logic        cin = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out;
    logic        zero, sign, carry, ovf, err;

    int errors = 0;
    int checks = 0;
    logic rdy_seen;

    seq_arith_unit #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .in1       (in1),
        .in2       (in2),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out),
        .zero      (zero),
        .sign      (sign),
        .carry     (carry),
        .ovf       (ovf),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Present one op at the falling edge; it is accepted on the next rise.
    task automatic send(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b, input logic c);
        @(negedge clk);
        op = o; in1 = a; in2 = b; cin = c; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in1 = 32'hDEAD_BEEF; in2 = 32'h0BAD_F00D;
    endtask

    // Cycles from accept to out_valid (1 = visible right after accept edge).
    task automatic wait_out(output int lat);
        lat = 1;
        rdy_seen = 1'b0;
        while (!out_valid && lat < 200) begin
            if (in_ready) rdy_seen = 1'b1;
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic take();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    // Issue, wait, check out / {zero,sign,carry,ovf,err} / latency.
    task automatic run(input string tag, input logic [2:0] o, input logic [31:0] a,
                       input logic [31:0] b, input logic c, input logic [31:0] eo,
                       input logic [4:0] ef, input int el, input logic hammer);
        int lat;
        send(o, a, b, c);
        if (hammer) begin
            op = 3'b000; in1 = 32'h1; in2 = 32'h1; in_valid = 1'b1;
        end
        wait_out(lat);
        in_valid = 1'b0;
        chk({tag, "_out"}, out, eo);
        chk({tag, "_flags"}, {27'h0, zero, sign, carry, ovf, err}, {27'h0, ef});
        chk({tag, "_lat"}, lat, el);
        if (el > 1) chk({tag, "_busy_rdy"}, {31'h0, rdy_seen}, 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] hold_out;
        logic [4:0]  hold_flags;
        logic        stable;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", {31'h0, out_valid}, 32'h0);
        chk("rst_out", out, 32'h0);
        chk("rst_flags", {27'h0, zero, sign, carry, ovf, err}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_in_ready", {31'h0, in_ready}, 32'h1);

        // Single-cycle ops
        run("add_wrap", 3'b000, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0, 5'b10100, 1, 1'b0); take();
        run("sub_ovf",  3'b001, 32'h8000_0000, 32'h0000_0001, 1'b0, 32'h7FFF_FFFF, 5'b00110, 1, 1'b0); take();
        run("slt",      3'b010, 32'h8000_0000, 32'h0000_0001, 1'b0, 32'h1, 5'b00000, 1, 1'b0); take();
        run("sltu",     3'b011, 32'h8000_0000, 32'h0000_0001, 1'b0, 32'h0, 5'b10000, 1, 1'b0); take();
        run("add_cin",  3'b000, 32'h7FFF_FFFF, 32'h0000_0000, 1'b1, 32'h8000_0000, 5'b01010, 1, 1'b0); take();
        run("sub_cin_ignored", 3'b001, 32'h0000_000A, 32'h0000_0003, 1'b1, 32'h7, 5'b00100, 1, 1'b0); take();
        run("rsv",      3'b111, 32'h1234_5678, 32'h1, 1'b0, 32'h0, 5'b10001, 1, 1'b0); take();

        // Multiply (inputs hammered during the first one must be ignored)
        run("mul",      3'b100, 32'h0001_2345, 32'h0000_0100, 1'b0, 32'h0123_4500, 5'b00000, 33, 1'b1); take();
        run("mul_ones", 3'b100, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'h1, 5'b00000, 33, 1'b0); take();
        run("mul_zero", 3'b100, 32'h0000_0000, 32'h0000_0005, 1'b0, 32'h0, 5'b10000, 33, 1'b0); take();

        // Divide / remainder
`ifdef ARITH_DIV_EN
        run("divu",      3'b101, 32'd100, 32'd7, 1'b0, 32'd14, 5'b00000, 33, 1'b0); take();
        run("remu",      3'b110, 32'd100, 32'd7, 1'b0, 32'd2, 5'b00000, 33, 1'b0); take();
        run("divu_zero", 3'b101, 32'h1234_5678, 32'h0, 1'b0, 32'hFFFF_FFFF, 5'b01000, 33, 1'b0); take();
        run("remu_zero", 3'b110, 32'h1234_5678, 32'h0, 1'b0, 32'h1234_5678, 5'b00000, 33, 1'b0); take();
        run("divu_big",  3'b101, 32'hF000_0000, 32'd3, 1'b0, 32'h5000_0000, 5'b00000, 33, 1'b0); take();
`else
        run("divu_off",  3'b101, 32'd100, 32'd7, 1'b0, 32'h0, 5'b10001, 1, 1'b0); take();
        run("remu_off",  3'b110, 32'd100, 32'd7, 1'b0, 32'h0, 5'b10001, 1, 1'b0); take();
`endif

        // Hold the result for 5 cycles, then back-to-back accept
        run("hold_add", 3'b000, 32'd5, 32'd6, 1'b0, 32'd11, 5'b00000, 1, 1'b0);
        hold_out   = out;
        hold_flags = {zero, sign, carry, ovf, err};
        stable     = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            if (out !== hold_out || {zero, sign, carry, ovf, err} !== hold_flags || out_valid !== 1'b1)
                stable = 1'b0;
        end
        chk("hold_stable", {31'h0, stable}, 32'h1);
        chk("hold_in_ready", {31'h0, in_ready}, 32'h0);
        @(negedge clk);
        out_ready = 1'b1;
        op = 3'b001; in1 = 32'd10; in2 = 32'd3; cin = 1'b0; in_valid = 1'b1;
        #1;
        chk("b2b_in_ready", {31'h0, in_ready}, 32'h1);
        @(posedge clk);
        #1;
        in_valid = 1'b0; out_ready = 1'b0;
        chk("b2b_valid", {31'h0, out_valid}, 32'h1);
        chk("b2b_out", out, 32'd7);
        chk("b2b_flags", {27'h0, zero, sign, carry, ovf, err}, {27'h0, 5'b00100});
        take();

        // Reset in the middle of a multiply
        send(3'b100, 32'h0001_2345, 32'h0000_0100, 1'b0);
        repeat (9) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("abort_valid", {31'h0, out_valid}, 32'h0);
        chk("abort_out", out, 32'h0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("abort_in_ready", {31'h0, in_ready}, 32'h1);
        chk("abort_idle_valid", {31'h0, out_valid}, 32'h0);
        run("post_abort_add", 3'b000, 32'd2, 32'd3, 1'b0, 32'd5, 5'b00000, 1, 1'b0);
        take();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
